// File: rtl/ped_walk_timer_pkg.sv
// Shared types and defaults for the pedestrian walk timer and its phase counter.
package ped_walk_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_FLASH = 2'd2,
        ST_DONE  = 2'd3
    } ped_state_e;

    localparam int PHASE_TICKS_DEF = 50;
    localparam int DIGIT_TICKS_DEF = 10;
    localparam int TEN_SEC_W       = 7;

endpackage

// File: rtl/ped_walk_timer_phase.sv
// Phase counter: tenth-of-a-second count across WALK+FLASH plus the digit sub-counter
// that tells the sequencer when the countdown digit should step.
module ped_phase_counter
    import ped_walk_timer_pkg::*;
#(
    parameter int PHASE_TICKS = PHASE_TICKS_DEF,
    parameter int DIGIT_TICKS = DIGIT_TICKS_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic                 i_tick_en,
    output logic [TEN_SEC_W-1:0] o_ten_sec,
    output logic                 o_digit_wrap,
    output logic                 o_phase_end
);

    localparam int SUB_W = $clog2(DIGIT_TICKS + 1);
    localparam logic [TEN_SEC_W-1:0] WALK_LAST  = TEN_SEC_W'(PHASE_TICKS - 1);
    localparam logic [TEN_SEC_W-1:0] FLASH_LAST = TEN_SEC_W'(2 * PHASE_TICKS - 1);
    localparam logic [SUB_W-1:0]     SUB_LAST   = SUB_W'(DIGIT_TICKS - 1);

    logic [TEN_SEC_W-1:0] r_ten_sec;
    logic [SUB_W-1:0]     r_sub;
    logic                 w_phase_end;
    logic                 w_digit_wrap;

    assign w_phase_end  = (r_ten_sec == WALK_LAST) || (r_ten_sec == FLASH_LAST);
    assign w_digit_wrap = (r_sub == SUB_LAST);

    // The last tick of FLASH returns the count to 0 so it never runs past the end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ten_sec <= '0;
            r_sub     <= '0;
        end else if (i_load) begin
            r_ten_sec <= '0;
            r_sub     <= '0;
        end else if (i_tick_en) begin
            r_ten_sec <= (r_ten_sec == FLASH_LAST) ? '0 : r_ten_sec + 1'b1;
            r_sub     <= (w_digit_wrap || w_phase_end) ? '0 : r_sub + 1'b1;
        end
    end

    assign o_ten_sec    = r_ten_sec;
    assign o_digit_wrap = w_digit_wrap;
    assign o_phase_end  = w_phase_end;

endmodule

// File: rtl/ped_walk_timer.sv
// Pedestrian crossing sequencer: latches walk requests, waits for the traffic grant,
// then runs WALK and FLASH phases with a countdown digit and a completion pulse.
module ped_walk_timer
    import ped_walk_timer_pkg::*;
#(
    parameter int PHASE_TICKS = PHASE_TICKS_DEF,
    parameter int DIGIT_TICKS = DIGIT_TICKS_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tick,
    input  logic                 i_ped_req,
    input  logic                 i_cross_ok,
    output logic [TEN_SEC_W-1:0] o_ten_sec,
    output logic [3:0]           o_countdown,
    output logic                 o_walk,
    output logic                 o_flash,
    output logic                 o_req_pending,
    output logic                 o_ped_done
);

    localparam logic [3:0] DIGIT_TOP = 4'(PHASE_TICKS / DIGIT_TICKS - 1);

    ped_state_e r_state;
    logic [3:0] r_countdown;
    logic       r_walk;
    logic       r_flash;
    logic       r_req_pending;
    logic       r_ped_done;

    logic w_grant;
    logic w_count_en;
    logic w_digit_wrap;
    logic w_phase_end;

    assign w_grant    = (r_state == ST_IDLE) && r_req_pending && i_cross_ok;
    assign w_count_en = i_tick && ((r_state == ST_WALK) || (r_state == ST_FLASH));

    ped_phase_counter #(
        .PHASE_TICKS (PHASE_TICKS),
        .DIGIT_TICKS (DIGIT_TICKS)
    ) u_phase (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (w_grant),
        .i_tick_en    (w_count_en),
        .o_ten_sec    (o_ten_sec),
        .o_digit_wrap (w_digit_wrap),
        .o_phase_end  (w_phase_end)
    );

    // A press in the grant cycle is absorbed by that grant; any other press is latched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_countdown   <= '0;
            r_walk        <= 1'b0;
            r_flash       <= 1'b0;
            r_req_pending <= 1'b0;
            r_ped_done    <= 1'b0;
        end else begin
            r_ped_done <= 1'b0;
            if (i_ped_req) begin
                r_req_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state       <= ST_WALK;
                        r_walk        <= 1'b1;
                        r_countdown   <= DIGIT_TOP;
                        r_req_pending <= 1'b0;
                    end
                end
                ST_WALK: begin
                    if (i_tick) begin
                        if (w_phase_end) begin
                            r_state     <= ST_FLASH;
                            r_walk      <= 1'b0;
                            r_flash     <= 1'b1;
                            r_countdown <= DIGIT_TOP;
                        end else if (w_digit_wrap) begin
                            r_countdown <= r_countdown - 1'b1;
                        end
                    end
                end
                ST_FLASH: begin
                    if (i_tick) begin
                        if (w_phase_end) begin
                            r_state     <= ST_DONE;
                            r_flash     <= 1'b0;
                            r_countdown <= '0;
                            r_ped_done  <= 1'b1;
                        end else if (w_digit_wrap) begin
                            r_countdown <= r_countdown - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_countdown   = r_countdown;
    assign o_walk        = r_walk;
    assign o_flash       = r_flash;
    assign o_req_pending = r_req_pending;
    assign o_ped_done    = r_ped_done;

endmodule

// File: tb/tb_ped_walk_timer.sv
// Scoreboard bench for ped_walk_timer: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_ped_walk_timer;
    import ped_walk_timer_pkg::*;

    typedef struct packed {
        logic [6:0] tenSec;
        logic [3:0] countdown;
        logic       walk;
        logic       flash;
        logic       reqPending;
        logic       pedDone;
    } snap_t;

    logic       clk;
    logic       rstN;
    logic       tick;
    logic       pedReq;
    logic       crossOk;
    logic [6:0] tenSec;
    logic [3:0] countdown;
    logic       walk;
    logic       flash;
    logic       reqPending;
    logic       pedDone;

    int checkCount = 0;
    int errorCount = 0;
    logic expPend = 1'b0;

    snap_t expQ[$];
    string nameQ[$];

    ped_walk_timer dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_tick        (tick),
        .i_ped_req     (pedReq),
        .i_cross_ok    (crossOk),
        .o_ten_sec     (tenSec),
        .o_countdown   (countdown),
        .o_walk        (walk),
        .o_flash       (flash),
        .o_req_pending (reqPending),
        .o_ped_done    (pedDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t actualSnap();
        return {tenSec, countdown, walk, flash, reqPending, pedDone};
    endfunction

    task automatic checkOutput(input snap_t exp, input string name);
        snap_t act;
        act = actualSnap();
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got ten=%0d cd=%0d walk=%b flash=%b pend=%b done=%b, want ten=%0d cd=%0d walk=%b flash=%b pend=%b done=%b",
                     name, act.tenSec, act.countdown, act.walk, act.flash, act.reqPending, act.pedDone,
                     exp.tenSec, exp.countdown, exp.walk, exp.flash, exp.reqPending, exp.pedDone);
        end
    endtask

    // Monitor: outputs are registered, so a snapshot pushed at a posedge is compared at the next negedge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front(), nameQ.pop_front());
        end
    end

    task automatic applyStimulus(input logic tk, input logic rq, input logic co,
                                 input logic [6:0] expTen, input logic [3:0] expCd,
                                 input logic expWalk, input logic expFlash,
                                 input logic expP, input logic expDone, input string name);
        @(negedge clk);
        tick    = tk;
        pedReq  = rq;
        crossOk = co;
        @(posedge clk);
        expQ.push_back({expTen, expCd, expWalk, expFlash, expP, expDone});
        nameQ.push_back(name);
    endtask

    // Runs ticks 1..stopAt of a crossing that has just been granted; optionally presses
    // the button on an idle cycle once the count has reached reqAt.
    task automatic runTicks(input int stopAt, input int reqAt);
        logic [6:0] eTen;
        logic [3:0] eCd;
        for (int k = 1; k <= stopAt; k++) begin
            if (k < 100) begin
                eTen = 7'(k);
                eCd  = 4'(4 - (k % 50) / 10);
                applyStimulus(1'b1, 1'b0, 1'b0, eTen, eCd, k < 50, k >= 50, expPend, 1'b0, "crossTick");
                if (k == reqAt) begin
                    expPend = 1'b1;
                    applyStimulus(1'b0, 1'b1, 1'b0, eTen, eCd, k < 50, k >= 50, expPend, 1'b0, "reqInCrossing");
                end
            end else begin
                applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0, expPend, 1'b1, "enterDone");
            end
        end
    endtask

    initial begin
        rstN    = 1'b0;
        tick    = 1'b0;
        pedReq  = 1'b0;
        crossOk = 1'b0;
        #1;
        checkOutput('0, "inReset");
        #11;
        rstN = 1'b1;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "idleTicks");
        end

        // Basic crossing: press with grant present, then a full 100-tick crossing.
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "pressLatched");
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "grantWalk");
        expPend = 1'b0;
        runTicks(100, -1);
        applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "tickInDoneIgnored");
        applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "backToIdle");

        // Wait for grant, then a press coinciding with the grant cycle is absorbed.
        applyStimulus(1'b0, 1'b1, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "pressNoGrant");
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "waitGrant");
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "grantAbsorbsPress");
        expPend = 1'b0;

        // Press at ten_sec=60 is held through DONE and served with no new press.
        runTicks(100, 60);
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "idlePending");
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "secondGrant");
        expPend = 1'b0;

        // Third crossing reset asynchronously at ten_sec=73 with a request pending.
        runTicks(73, 73);
        @(negedge clk);
        tick    = 1'b0;
        pedReq  = 1'b0;
        crossOk = 1'b1;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput('0, "asyncReset");
        #2;
        rstN = 1'b1;
        expPend = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 7'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "idleAfterReset");
        applyStimulus(1'b1, 1'b0, 1'b1, 7'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "noGrantWithoutReq");

        @(negedge clk);
        @(negedge clk);
        checkCount++;
        if (expQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL drain: got %0d entries left, want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no end of run, want completion before 200000");
        $fatal(1, "[TB] timeout");
    end

endmodule
